// File: rtl/sram_frame_reader.sv
// sram_frame_reader
// Scans one stored frame out of an asynchronous SRAM in raster order. Only one
// read is in flight at a time. Each captured pixel (DQ[0]) is offered on a
// valid/ready port, and the next address is issued only after the consumer
// accepts the current pixel.
module sram_frame_reader #(
   parameter int H_PIX   = 320,
   parameter int V_PIX   = 240,
   parameter int RD_WAIT = 2
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic        init_done,
   input  logic        start,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_data,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        pix_eof,
   output logic        busy
);

   localparam logic [8:0] X_LAST   = 9'(H_PIX - 1);
   localparam logic [8:0] Y_LAST   = 9'(V_PIX - 1);
   localparam logic [3:0] CNT_LOAD = 4'(RD_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state, state_n;
   logic [8:0]  px, px_n, py, py_n;
   logic [3:0]  cnt, cnt_n;
   logic        oe_n_q, oe_n_n;
   logic        valid_n, data_n, eof_n, busy_n;
   logic [8:0]  x_n, y_n;

   // Upper data lines carry nothing this reader needs.
   logic        unused_dq_hi;

   // Read-only master: the bus is never driven, write is never strobed,
   // the chip and both byte lanes stay enabled.
   assign SRAM_DQ      = 16'hzzzz;
   assign SRAM_WE_N    = 1'b1;
   assign SRAM_CE_N    = 1'b0;
   assign SRAM_UB_N    = 1'b0;
   assign SRAM_LB_N    = 1'b0;
   assign SRAM_OE_N    = oe_n_q;
   assign unused_dq_hi = ^SRAM_DQ[15:1];

   // The scan counters always stay in range, so they drive the address
   // directly. This holds the address steady while a pixel waits in HOLD.
   assign SRAM_ADDR = {px, py};

   // Next-state logic: walk the frame one access at a time.
   always_comb begin
      state_n = state;
      px_n    = px;
      py_n    = py;
      cnt_n   = cnt;
      oe_n_n  = oe_n_q;
      valid_n = pix_valid;
      data_n  = pix_data;
      x_n     = pix_x;
      y_n     = pix_y;
      eof_n   = pix_eof;
      busy_n  = busy;
      case (state)
         IDLE: begin
            if (start && init_done) begin
               state_n = ADDR;
               px_n    = 9'd0;
               py_n    = 9'd0;
               busy_n  = 1'b1;
               oe_n_n  = 1'b0;
            end
         end
         ADDR: begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_n = HOLD;
               valid_n = 1'b1;
               data_n  = SRAM_DQ[0];
               x_n     = px;
               y_n     = py;
               eof_n   = (px == X_LAST) && (py == Y_LAST);
               oe_n_n  = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (pix_ready) begin
               valid_n = 1'b0;
               eof_n   = 1'b0;
               if (pix_eof) begin
                  // Frame complete: counters stay parked on the last pixel.
                  state_n = DONE;
                  busy_n  = 1'b0;
               end else begin
                  state_n = ADDR;
                  oe_n_n  = 1'b0;
                  if (px == X_LAST) begin
                     px_n = 9'd0;
                     py_n = py + 9'd1;
                  end else begin
                     px_n = px + 9'd1;
                  end
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any scan in progress.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         px        <= 9'd0;
         py        <= 9'd0;
         cnt       <= 4'd0;
         oe_n_q    <= 1'b1;
         pix_valid <= 1'b0;
         pix_data  <= 1'b0;
         pix_x     <= 9'd0;
         pix_y     <= 9'd0;
         pix_eof   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         px        <= px_n;
         py        <= py_n;
         cnt       <= cnt_n;
         oe_n_q    <= oe_n_n;
         pix_valid <= valid_n;
         pix_data  <= data_n;
         pix_x     <= x_n;
         pix_y     <= y_n;
         pix_eof   <= eof_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: doc/sram_frame_reader.md
SRAM_FRAME_READER -- requirements
Module: sram_frame_reader

Interface
REQ-001 Parameter H_PIX, default 320, pixels per row (1..512).
REQ-002 Parameter V_PIX, default 240, rows per frame (1..512).
REQ-003 Parameter RD_WAIT, default 2, SRAM access wait cycles after address/OE valid (1..15).
REQ-004 CLOCK_50  in  1  single clock; all state changes on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 init_done  in  1  frame image present in SRAM; level, sampled in IDLE only.
REQ-007 start  in  1  one-cycle pulse requesting one full frame scan.
REQ-008 SRAM_ADDR  out  18  read address = {px, py}: px in [17:9], py in [8:0].
REQ-009 SRAM_DQ  inout  16  never driven by this block (constant high-Z).
REQ-010 SRAM_WE_N / SRAM_OE_N / SRAM_CE_N / SRAM_UB_N / SRAM_LB_N  out  1 each  SRAM strobes.
REQ-011 pix_valid  out  1  pix_data/pix_x/pix_y/pix_eof are valid.
REQ-012 pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready.
REQ-013 pix_data  out  1  captured SRAM_DQ[0].
REQ-014 pix_x  out  9  column of pix_data; pix_y  out  9  row of pix_data.
REQ-015 pix_eof  out  1  high with the last pixel of the frame (x=H_PIX-1, y=V_PIX-1).
REQ-016 busy  out  1  high from start acceptance until the final pixel handshake.

Function
REQ-017 SRAM_WE_N shall be 1 at all times; SRAM_CE_N, SRAM_UB_N, SRAM_LB_N shall be 0 at all times.
REQ-018 FSM states: IDLE, ADDR, WAIT, HOLD, DONE.
REQ-019 IDLE: start && init_done -> ADDR with px=0, py=0, busy=1; start while init_done=0 is ignored (no state change).
REQ-020 ADDR: drive SRAM_ADDR={px,py}, SRAM_OE_N=0, load wait counter to RD_WAIT-1, go to WAIT next cycle.
REQ-021 WAIT: hold address and OE_N=0; decrement counter; at counter 0, capture SRAM_DQ[0] into pix_data, set pix_valid=1, go to HOLD.
REQ-022 Read latency: pix_valid rises exactly RD_WAIT+1 cycles after entering ADDR.
REQ-023 HOLD: pix_valid and pix_data/pix_x/pix_y/pix_eof held stable until pix_ready=1; OE_N returns to 1 on leaving WAIT.
REQ-024 On handshake in HOLD: pix_valid=0 next cycle; advance px; px wraps H_PIX-1 -> 0 with py+1; go to ADDR.
REQ-025 Handshake on pixel (H_PIX-1, V_PIX-1): go to DONE, not ADDR; px/py do not advance past frame end.
REQ-026 DONE: lasts one cycle, busy=0, then IDLE.
REQ-027 start while busy=1 shall be ignored; no queued request.
REQ-028 pix_ready while pix_valid=0 shall have no effect.
REQ-029 Only one SRAM access outstanding at any time; no prefetch.
REQ-030 Address counters 9-bit unsigned; no value >= H_PIX (x) or >= V_PIX (y) ever appears on SRAM_ADDR.

Reset
REQ-031 rst_n=0 asynchronously forces: state IDLE, px=py=0, pix_valid=0, pix_data=0, pix_x=pix_y=0, pix_eof=0, busy=0, SRAM_OE_N=1, SRAM_ADDR=0.
REQ-032 Reset mid-frame abandons the scan; after release, no pixel is presented until a new start is accepted.
REQ-033 Reset release requires no synchronisation inside this block; first active edge after release obeys REQ-019.

Verification
REQ-034 init_done=0, start pulse -> busy stays 0, pix_valid stays 0, SRAM_OE_N stays 1.
REQ-035 H_PIX=4, V_PIX=2, RD_WAIT=2, SRAM model returns DQ[0]=px^py, pix_ready=1 -> 8 pixels in raster order (0,0)..(3,1), data matches, pix_eof only on (3,1), pix_valid 3 cycles after each ADDR, busy drops after 8th handshake.
REQ-036 Same config, pix_ready held 0 for 5 cycles on pixel (2,0) -> pix_valid/pix_data/pix_x/pix_y stable for all 5 cycles, SRAM_ADDR not advanced, next address {3,0} only after handshake.
REQ-037 Row wrap H_PIX=3: handshake on (2,0) -> next SRAM_ADDR = {9'd0, 9'd1}.
REQ-038 rst_n pulsed low while in WAIT on pixel (1,1) -> all outputs at reset values immediately (asynchronous), no further pixels until new start; new start rescans from (0,0).
REQ-039 Second start pulse during busy -> ignored; exactly H_PIX*V_PIX pixels delivered, one pix_eof.
